// File: rtl/cpu_datapath.sv
// cpu_datapath: PC, instruction register, 16x16 register file, ALU and
// registered Z/N/C flags, driven by per-cycle command strobes.
module cpu_datapath #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pc_clr,
  input  logic              i_pr_id,
  input  logic              i_pc_ic,
  output logic [PC_W-1:0]   o_i_addr,
  input  logic [DATA_W-1:0] i_i_rdata,
  output logic [DATA_W-1:0] o_ir,
  input  logic [DATA_W-1:0] i_d_rdata,
  output logic [DATA_W-1:0] o_d_wdata,
  input  logic              i_rf_s,
  input  logic              i_rf_w_en,
  input  logic [3:0]        i_rf_a_addr,
  input  logic [3:0]        i_rf_b_addr,
  input  logic [3:0]        i_rf_w_addr,
  input  logic [2:0]        i_alu_s,
  output logic              o_alu_z,
  output logic              o_alu_n,
  output logic              o_alu_c
);

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5,
    ALU_NOT  = 3'd6,
    ALU_SHL  = 3'd7
  } alu_op_e;

  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_rf [16];
  logic              r_z;
  logic              r_n;
  logic              r_c;

  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_alu_q;
  logic              w_alu_c;
  logic [DATA_W-1:0] w_wb;
  logic              w_flag_upd;
  alu_op_e           w_op;

  assign w_op       = alu_op_e'(i_alu_s);
  assign w_a        = r_rf[i_rf_a_addr];
  assign w_b        = r_rf[i_rf_b_addr];
  assign w_wb       = i_rf_s ? i_d_rdata : w_alu_q;
  assign w_flag_upd = i_rf_w_en & ~i_rf_s;

  assign o_i_addr  = r_pc;
  assign o_ir      = r_ir;
  assign o_d_wdata = w_a;
  assign o_alu_z   = r_z;
  assign o_alu_n   = r_n;
  assign o_alu_c   = r_c;

  // ALU: result and carry-out for the selected function
  always_comb begin
    w_sum   = '0;
    w_alu_q = '0;
    w_alu_c = 1'b0;
    case (w_op)
      ALU_PASS: w_alu_q = w_a;
      ALU_ADD: begin
        w_sum   = {1'b0, w_a} + {1'b0, w_b};
        w_alu_q = w_sum[DATA_W-1:0];
        w_alu_c = w_sum[DATA_W];
      end
      ALU_SUB: begin
        // A + ~B + 1: carry out set means no borrow
        w_sum   = {1'b0, w_a} + {1'b0, ~w_b} + {{DATA_W{1'b0}}, 1'b1};
        w_alu_q = w_sum[DATA_W-1:0];
        w_alu_c = w_sum[DATA_W];
      end
      ALU_AND: w_alu_q = w_a & w_b;
      ALU_OR:  w_alu_q = w_a | w_b;
      ALU_XOR: w_alu_q = w_a ^ w_b;
      ALU_NOT: w_alu_q = ~w_a;
      ALU_SHL: begin
        w_alu_q = {w_a[DATA_W-2:0], 1'b0};
        w_alu_c = w_a[DATA_W-1];
      end
      default: w_alu_q = w_a;
    endcase
  end

  // PC and IR: clear has priority over fetch/increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= '0;
      r_ir <= '0;
    end else if (i_pc_clr) begin
      r_pc <= '0;
      r_ir <= '0;
    end else begin
      if (i_pc_ic) r_pc <= r_pc + PC_W'(1);
      if (i_pr_id) r_ir <= i_i_rdata;
    end
  end

  // Register file write-back; reads are combinational with no bypass
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < 16; i++) r_rf[i] <= '0;
    end else if (i_rf_w_en) begin
      r_rf[i_rf_w_addr] <= w_wb;
    end
  end

  // Flags capture only on ALU write-back, not on memory loads or idle cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_z <= 1'b0;
      r_n <= 1'b0;
      r_c <= 1'b0;
    end else if (w_flag_upd) begin
      r_z <= (w_alu_q == '0);
      r_n <= w_alu_q[DATA_W-1];
      r_c <= w_alu_c;
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: stimulus pushes expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cpu_datapath;

  localparam int SEL_IADDR = 0;
  localparam int SEL_IR    = 1;
  localparam int SEL_WDATA = 2;
  localparam int SEL_Z     = 3;
  localparam int SEL_N     = 4;
  localparam int SEL_C     = 5;

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [15:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_clr, pr_id, pc_ic;
  logic [7:0]  i_addr;
  logic [15:0] i_rdata, ir, d_rdata, d_wdata;
  logic        rf_s, rf_w_en;
  logic [3:0]  a_addr, b_addr, w_addr;
  logic [2:0]  alu_s;
  logic        z, n, c;

  exp_t        q[$];
  int unsigned cyc_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  cpu_datapath #(.DATA_W(16), .PC_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_pc_clr(pc_clr), .i_pr_id(pr_id), .i_pc_ic(pc_ic),
    .o_i_addr(i_addr), .i_i_rdata(i_rdata), .o_ir(ir),
    .i_d_rdata(d_rdata), .o_d_wdata(d_wdata),
    .i_rf_s(rf_s), .i_rf_w_en(rf_w_en),
    .i_rf_a_addr(a_addr), .i_rf_b_addr(b_addr), .i_rf_w_addr(w_addr),
    .i_alu_s(alu_s),
    .o_alu_z(z), .o_alu_n(n), .o_alu_c(c)
  );

  // Instruction memory model: word at address a is {~a, a}
  assign i_rdata = {~i_addr, i_addr};

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt = cyc_cnt + 1;

  function automatic logic [15:0] actual(int sel);
    case (sel)
      SEL_IADDR: return {8'h00, i_addr};
      SEL_IR:    return ir;
      SEL_WDATA: return d_wdata;
      SEL_Z:     return {15'h0, z};
      SEL_N:     return {15'h0, n};
      default:   return {15'h0, c};
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      exp_t e;
      logic [15:0] a;
      e = q.pop_front();
      a = actual(e.sel);
      checks++;
      if (a !== e.exp) begin
        failures++;
        $display("FAIL %s: got 0x%04h expected 0x%04h", e.name, a, e.exp);
      end
    end
  end

  task automatic expect_val(int sel, logic [15:0] v, string name);
    exp_t e;
    e.cyc = cyc_cnt; e.sel = sel; e.exp = v; e.name = name;
    q.push_back(e);
  endtask

  task automatic expect_flags(logic ez, logic en, logic ec, string name);
    expect_val(SEL_Z, {15'h0, ez}, {name, ".Z"});
    expect_val(SEL_N, {15'h0, en}, {name, ".N"});
    expect_val(SEL_C, {15'h0, ec}, {name, ".C"});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_clr = 0; pr_id = 0; pc_ic = 0;
    rf_s = 0; rf_w_en = 0; w_addr = 0; alu_s = 0;
  endtask

  task automatic load_reg(logic [3:0] r, logic [15:0] v);
    idle();
    rf_s = 1; rf_w_en = 1; w_addr = r; d_rdata = v;
    step();
    idle();
  endtask

  task automatic alu_op(logic [2:0] op, logic [3:0] ra, logic [3:0] rb, logic [3:0] rw);
    idle();
    alu_s = op; a_addr = ra; b_addr = rb; w_addr = rw; rf_w_en = 1;
    step();
    idle();
  endtask

  task automatic read_chk(logic [3:0] r, logic [15:0] v, string name);
    a_addr = r;
    expect_val(SEL_WDATA, v, name);
  endtask

  initial begin
    rst_n = 0; idle(); a_addr = 0; b_addr = 0; d_rdata = 0;
    step(); step();
    rst_n = 1;

    // Random commands, then asynchronous reset mid-cycle
    for (int i = 0; i < 6; i++) begin
      {pc_clr, pr_id, pc_ic, rf_s, rf_w_en} = 5'($urandom);
      {a_addr, b_addr, w_addr, alu_s} = 15'($urandom);
      d_rdata = 16'($urandom);
      step();
    end
    #2 rst_n = 0;
    expect_val(SEL_IADDR, 16'h0000, "rst_iaddr");
    expect_val(SEL_IR, 16'h0000, "rst_ir");
    expect_flags(0, 0, 0, "rst");
    step();
    idle();
    rst_n = 1;
    for (int r = 0; r < 16; r++) begin
      step();
      read_chk(4'(r), 16'h0000, $sformatf("rst_rf%0d", r));
    end

    // Fetch loop across PC wrap
    idle(); pc_clr = 1;
    step();
    expect_val(SEL_IADDR, 16'h0000, "clr_iaddr");
    expect_val(SEL_IR, 16'h0000, "clr_ir");
    idle(); pc_ic = 1; pr_id = 1;
    for (int k = 1; k <= 256; k++) begin
      logic [7:0] pk, pp;
      step();
      if (k % 32 == 1 || k == 256) begin
        pk = 8'(k); pp = 8'(k - 1);
        expect_val(SEL_IADDR, {8'h00, pk}, $sformatf("fetch_iaddr_%0d", k));
        expect_val(SEL_IR, {~pp, pp}, $sformatf("fetch_ir_%0d", k));
      end
    end
    step(); step(); step();
    expect_val(SEL_IADDR, 16'h0003, "fetch_iaddr_post");
    expect_val(SEL_IR, 16'hFD02, "fetch_ir_post");
    pc_clr = 1;
    step();
    expect_val(SEL_IADDR, 16'h0000, "clr_all_iaddr");
    expect_val(SEL_IR, 16'h0000, "clr_all_ir");
    idle();

    // Add with carry out, result zero
    load_reg(1, 16'hFFFF);
    load_reg(2, 16'h0001);
    expect_flags(0, 0, 0, "preadd");
    alu_op(1, 1, 2, 4);
    read_chk(4, 16'h0000, "add_r4");
    expect_flags(1, 0, 1, "add");

    // Load leaves flags alone
    load_reg(3, 16'hBEEF);
    read_chk(3, 16'hBEEF, "load_r3");
    expect_flags(1, 0, 1, "load");

    // ALU op without write enable leaves flags alone
    alu_s = 2; a_addr = 3; b_addr = 1;
    step();
    expect_flags(1, 0, 1, "noweb");

    // Subtract with and without borrow
    load_reg(5, 16'h0005);
    load_reg(6, 16'h0007);
    alu_op(2, 5, 6, 7);
    read_chk(7, 16'hFFFE, "sub_r7");
    expect_flags(0, 1, 0, "sub_borrow");
    step();
    alu_op(2, 6, 5, 9);
    read_chk(9, 16'h0002, "sub_r9");
    expect_flags(0, 0, 1, "sub_nob");
    step();

    // Same-cycle read/write returns old value until the edge
    load_reg(8, 16'h1111);
    rf_s = 1; rf_w_en = 1; w_addr = 8; a_addr = 8; d_rdata = 16'h2222;
    expect_val(SEL_WDATA, 16'h1111, "rw_old");
    step();
    idle();
    expect_val(SEL_WDATA, 16'h2222, "rw_new");

    // Shift left with carry from bit 15
    load_reg(10, 16'h8001);
    alu_op(7, 10, 0, 11);
    read_chk(11, 16'h0002, "shl_r11");
    expect_flags(0, 0, 1, "shl");
    step();

    // XOR/AND/NOT sanity with N flag from result
    alu_op(5, 3, 8, 12);
    read_chk(12, 16'h9CCD, "xor_r12");
    expect_flags(0, 1, 0, "xor");
    step();
    alu_op(6, 12, 0, 13);
    read_chk(13, 16'h6332, "not_r13");
    expect_flags(0, 0, 0, "not");
    step();

    // Drain scoreboard with a bounded wait
    for (int t = 0; t < 20 && q.size() > 0; t++) step();
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
